// File: rtl/ua_address_pipe.sv
// ua_address_pipe
//   Address-generation unit for load/store reservation stations. Each issue
//   computes base+offset, carries it through a LAT-stage pipeline together
//   with the destination register, the issuing RS ID and the store data, and
//   lands in a DEPTH-entry result FIFO. The FIFO head is offered to the CDB.
//
//   A credit counter (occupancy) covers queued plus in-flight entries. Every
//   accepted issue therefore owns a FIFO slot, and the pipeline never stalls.
//
// Ports
//   CLK, CLR          clock, synchronous active-high reset
//   start             issue request, accepted when busy=0
//   finalizado        CDB has consumed the head entry (pop)
//   ID_RS_in          issuing reservation-station ID
//   Dado1, Dado2      offset and base address
//   Dado3             store data
//   OP_Rd             {opcode, Rd}; only Rd is kept
//   Resultado         head entry {Rd, ID_RS, address}, 0 when empty
//   StoreData         head entry store data, 0 when empty
//   ovf               head entry carry-out of the address add, 0 when empty
//   confirmacao       head entry valid
//   busy              no credit left (occupancy == DEPTH)
//   desWrAS           CDB write disable, NOT confirmacao
//   occupancy         queued + in-flight entries
module ua_address_pipe #(
    parameter int DW    = 16,
    parameter int RSW   = 4,
    parameter int RDW   = 3,
    parameter int OPW   = 3,
    parameter int DEPTH = 4,
    parameter int LAT   = 1
) (
    input  logic                          CLK,
    input  logic                          CLR,
    input  logic                          start,
    input  logic                          finalizado,
    input  logic [RSW-1:0]                ID_RS_in,
    input  logic [DW-1:0]                 Dado1,
    input  logic [DW-1:0]                 Dado2,
    input  logic [DW-1:0]                 Dado3,
    input  logic [OPW+RDW-1:0]            OP_Rd,
    output logic [RDW+RSW+DW-1:0]         Resultado,
    output logic [DW-1:0]                 StoreData,
    output logic                          ovf,
    output logic                          confirmacao,
    output logic                          busy,
    output logic                          desWrAS,
    output logic [$clog2(DEPTH+1)-1:0]    occupancy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    typedef struct packed {
        logic [RDW-1:0] rd;
        logic [RSW-1:0] id;
        logic [DW-1:0]  addr;
        logic           carry;
        logic [DW-1:0]  sdata;
    } entry_t;

    // Unsigned address add; the extra MSB is the carry-out.
    function automatic logic [DW:0] add_carry(input logic [DW-1:0] a,
                                              input logic [DW-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    // Pointer increment modulo DEPTH, so non-power-of-two depths wrap correctly.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    // The opcode is never stored; the reduction only marks those bits as intentionally dropped.
    logic unused_opcode;
    assign unused_opcode = ^OP_Rd[OPW+RDW-1:RDW];

    logic [LAT:1]  vld_q, vld_d;
    entry_t        pipe_q [1:LAT];
    entry_t        pipe_d [1:LAT];
    entry_t        mem_q  [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] occ_q, occ_d;
    logic          accept, push, pop;
    logic [DW:0]   sum;
    entry_t        head;

    always_comb begin
        busy   = (occ_q == CW'(DEPTH));
        accept = start && !busy;
        pop    = finalizado && (cnt_q != '0);
        push   = vld_q[LAT];
        sum    = add_carry(Dado1, Dado2);

        // Stage 1: capture the issue and the address sum.
        vld_d[1]  = accept;
        pipe_d[1] = '{rd: OP_Rd[RDW-1:0], id: ID_RS_in, addr: sum[DW-1:0],
                      carry: sum[DW], sdata: Dado3};

        // Stages 2..LAT: plain delay, one issue per cycle, no stall.
        for (int k = 2; k <= LAT; k++) begin
            vld_d[k]  = vld_q[k-1];
            pipe_d[k] = pipe_q[k-1];
        end

        // Queue tail: the last stage writes the FIFO at the next edge.
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        cnt_d    = cnt_q + CW'(push) - CW'(pop);
        // Credits are taken at accept time, so an in-flight entry always has a slot.
        occ_d    = occ_q + CW'(accept) - CW'(pop);
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            vld_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            occ_q    <= '0;
        end else begin
            vld_q    <= vld_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            occ_q    <= occ_d;
        end
    end

    // Data registers carry no reset; validity is tracked by vld_q and cnt_q.
    always_ff @(posedge CLK) begin
        for (int k = 1; k <= LAT; k++) begin
            pipe_q[k] <= pipe_d[k];
        end
        if (push) begin
            mem_q[wr_ptr_q] <= pipe_q[LAT];
        end
    end

    // Head presentation, forced to zero while the queue is empty.
    always_comb begin
        head        = mem_q[rd_ptr_q];
        confirmacao = (cnt_q != '0);
        desWrAS     = !confirmacao;
        occupancy   = occ_q;
        Resultado   = confirmacao ? {head.rd, head.id, head.addr} : '0;
        StoreData   = confirmacao ? head.sdata : '0;
        ovf         = confirmacao ? head.carry : 1'b0;
    end

endmodule

// File: tb/tb_ua_address_pipe.sv
// Bench for ua_address_pipe: two instances share one stimulus stream.
//   inst 0: defaults (DEPTH=4, LAT=1)
//   inst 1: DEPTH=3, LAT=3 (non-power-of-two wrap, deepest pipeline)
// The reference model tracks each instance as an ordered list of issued
// entries, each stamped with the cycle it becomes visible. It counts issued
// minus popped entries for the credits.
module tb_ua_address_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        clr, start, fin;
    logic [3:0]  id;
    logic [15:0] d1, d2, d3;
    logic [5:0]  op_rd;

    logic [22:0] res_a, res_b;
    logic [15:0] sd_a, sd_b;
    logic        ovf_a, ovf_b, conf_a, conf_b, busy_a, busy_b, dw_a, dw_b;
    logic [2:0]  occ_a;
    logic [1:0]  occ_b;

    ua_address_pipe u_a (
        .CLK(clk), .CLR(clr), .start(start), .finalizado(fin), .ID_RS_in(id),
        .Dado1(d1), .Dado2(d2), .Dado3(d3), .OP_Rd(op_rd),
        .Resultado(res_a), .StoreData(sd_a), .ovf(ovf_a), .confirmacao(conf_a),
        .busy(busy_a), .desWrAS(dw_a), .occupancy(occ_a)
    );

    ua_address_pipe #(.DEPTH(3), .LAT(3)) u_b (
        .CLK(clk), .CLR(clr), .start(start), .finalizado(fin), .ID_RS_in(id),
        .Dado1(d1), .Dado2(d2), .Dado3(d3), .OP_Rd(op_rd),
        .Resultado(res_b), .StoreData(sd_b), .ovf(ovf_b), .confirmacao(conf_b),
        .busy(busy_b), .desWrAS(dw_b), .occupancy(occ_b)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state
    int          cyc = 0;
    int          wr_n [2];
    int          rd_n [2];
    int          rdy  [2][64];
    logic [22:0] e_res[2][64];
    logic [15:0] e_sd [2][64];
    logic        e_ovf[2][64];

    function automatic int dep(input int i);
        return (i == 0) ? 4 : 3;
    endfunction

    function automatic int lat(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic bit head_vis(input int i);
        return (rd_n[i] < wr_n[i]) && (rdy[i][rd_n[i] % 64] <= cyc);
    endfunction

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_outputs();
        for (int i = 0; i < 2; i++) begin
            bit          v;
            int          h;
            logic [22:0] o_res;
            logic [15:0] o_sd;
            logic        o_ovf, o_conf, o_busy, o_dw;
            logic [2:0]  o_occ;
            v = head_vis(i);
            h = rd_n[i] % 64;
            if (i == 0) begin
                o_res = res_a; o_sd = sd_a; o_ovf = ovf_a; o_conf = conf_a;
                o_busy = busy_a; o_dw = dw_a; o_occ = occ_a;
            end else begin
                o_res = res_b; o_sd = sd_b; o_ovf = ovf_b; o_conf = conf_b;
                o_busy = busy_b; o_dw = dw_b; o_occ = {1'b0, occ_b};
            end
            check_val($sformatf("conf%0d", i), 64'(o_conf), 64'(v));
            check_val($sformatf("deswr%0d", i), 64'(o_dw), 64'(!v));
            check_val($sformatf("busy%0d", i), 64'(o_busy), 64'((wr_n[i] - rd_n[i]) == dep(i)));
            check_val($sformatf("occ%0d", i), 64'(o_occ), 64'(wr_n[i] - rd_n[i]));
            check_val($sformatf("res%0d", i), 64'(o_res), v ? 64'(e_res[i][h]) : 64'd0);
            check_val($sformatf("sdata%0d", i), 64'(o_sd), v ? 64'(e_sd[i][h]) : 64'd0);
            check_val($sformatf("ovf%0d", i), 64'(o_ovf), v ? 64'(e_ovf[i][h]) : 64'd0);
        end
    endtask

    // One clock: decide accept/pop from pre-edge state, update the model, check.
    task automatic step();
        bit          acc[2];
        bit          pp[2];
        logic [16:0] s;
        int          idx;
        s = {1'b0, d1} + {1'b0, d2};
        for (int i = 0; i < 2; i++) begin
            acc[i] = start && ((wr_n[i] - rd_n[i]) < dep(i));
            pp[i]  = fin && head_vis(i);
        end
        @(posedge clk);
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (clr) begin
                wr_n[i] = 0;
                rd_n[i] = 0;
            end else begin
                if (pp[i]) rd_n[i]++;
                if (acc[i]) begin
                    idx = wr_n[i] % 64;
                    e_res[i][idx] = {op_rd[2:0], id, s[15:0]};
                    e_sd[i][idx]  = d3;
                    e_ovf[i][idx] = s[16];
                    rdy[i][idx]   = cyc + lat(i);
                    wr_n[i]++;
                end
            end
        end
        #1;
        check_outputs();
    endtask

    task automatic rand_data();
        id    = 4'($urandom);
        d1    = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
        d2    = 16'($urandom);
        d3    = 16'($urandom);
        op_rd = 6'($urandom);
    endtask

    task automatic set_issue(input logic [3:0] i_id, input logic [2:0] rd,
                             input logic [15:0] a, input logic [15:0] b);
        start = 1'b1;
        id    = i_id;
        d1    = a;
        d2    = b;
        d3    = 16'($urandom);
        op_rd = {3'($urandom), rd};
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            wr_n[i] = 0;
            rd_n[i] = 0;
        end
        // Reset with start and finalizado asserted: reset must win.
        clr = 1'b1; start = 1'b1; fin = 1'b1;
        rand_data();
        step();
        step();
        clr = 1'b0; start = 1'b0; fin = 1'b0;
        step();

        // Single issue: 0x0010 + 0x1000, ID 5, Rd 3.
        set_issue(4'd5, 3'd3, 16'h0010, 16'h1000);
        step();
        start = 1'b0;
        repeat (3) step();
        check_val("single_res_a", 64'(res_a), 64'({3'd3, 4'd5, 16'h1010}));
        check_val("single_res_b", 64'(res_b), 64'({3'd3, 4'd5, 16'h1010}));
        fin = 1'b1;
        step();
        fin = 1'b0;
        step();

        // Carry-out of the address add.
        set_issue(4'd9, 3'd6, 16'hFFFF, 16'h0002);
        step();
        start = 1'b0;
        repeat (3) step();
        check_val("carry_addr", 64'(res_a[15:0]), 64'h0001);
        check_val("carry_ovf", 64'(ovf_a), 64'd1);
        // Second pop attempt lands on an empty queue.
        fin = 1'b1;
        repeat (3) step();
        fin = 1'b0;

        // Fill without popping; extra starts must be ignored.
        start = 1'b1;
        for (int n = 0; n < 7; n++) begin
            rand_data();
            step();
        end
        check_val("fill_busy_a", 64'(busy_a), 64'd1);
        check_val("fill_occ_a", 64'(occ_a), 64'd4);
        start = 1'b0; fin = 1'b1;
        repeat (8) step();
        fin = 1'b0;

        // Two queued, then accept and pop together for 10 issues.
        start = 1'b1;
        repeat (2) begin rand_data(); step(); end
        start = 1'b0;
        repeat (3) step();
        start = 1'b1; fin = 1'b1;
        for (int n = 0; n < 10; n++) begin
            rand_data();
            step();
            check_val("steady_occ_a", 64'(occ_a), 64'd2);
        end
        start = 1'b0;
        repeat (8) step();
        fin = 1'b0;

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            rand_data();
            start = ($urandom_range(0, 9) < 7);
            fin   = ($urandom_range(0, 1) == 1);
            step();
        end

        // Reset mid-operation with entries in flight and queued.
        fin = 1'b0; start = 1'b1;
        repeat (3) begin rand_data(); step(); end
        clr = 1'b1; fin = 1'b1;
        step();
        clr = 1'b0; start = 1'b0;
        repeat (6) step();
        fin = 1'b0;

        for (int n = 0; n < 200; n++) begin
            rand_data();
            start = ($urandom_range(0, 9) < 6);
            fin   = ($urandom_range(0, 9) < 4);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ua_address_pipe.md
UA_ADDRESS_PIPE -- requirements
Module: ua_address_pipe

Parameters
REQ-001 The block SHALL have parameter DW, default 16, giving the data and address width.
REQ-002 The block SHALL have parameter RSW, default 4, giving the reservation-station ID width.
REQ-003 The block SHALL have parameter RDW, default 3, giving the destination-register field width.
REQ-004 The block SHALL have parameter OPW, default 3, giving the opcode field width.
REQ-005 The block SHALL have parameter DEPTH, default 4, giving the result-queue entries; legal range 2..16.
REQ-006 The block SHALL have parameter LAT, default 1, giving the adder pipeline stages; legal range 1..3.

Interface
REQ-007 CLK  in  1  clock; all state changes on the rising edge.
REQ-008 CLR  in  1  reset, synchronous, active-high.
REQ-009 start  in  1  issue request from a reservation station.
REQ-010 finalizado  in  1  CDB arbiter has consumed the head result (pop).
REQ-011 ID_RS_in  in  RSW  ID of the issuing reservation station.
REQ-012 Dado1  in  DW  offset.
REQ-013 Dado2  in  DW  base address.
REQ-014 Dado3  in  DW  store data.
REQ-015 OP_Rd  in  OPW+RDW  {opcode, Rd}, with Rd in the low RDW bits.
REQ-016 Resultado  out  RDW+RSW+DW  head entry as {Rd, ID_RS, address}.
REQ-017 StoreData  out  DW  Dado3 captured with the head entry.
REQ-018 ovf  out  1  head entry's Dado1+Dado2 carried out of DW bits.
REQ-019 confirmacao  out  1  head entry valid.
REQ-020 busy  out  1  block cannot accept start this cycle.
REQ-021 desWrAS  out  1  CDB write disable, equal to NOT confirmacao.
REQ-022 occupancy  out  $clog2(DEPTH+1)  queued entries plus in-flight entries.

Function
REQ-023 An issue SHALL be accepted on a rising edge where start=1 and busy=0; start with busy=1 SHALL be ignored, with no state change.
REQ-024 On accept, the block SHALL capture ID_RS_in, OP_Rd Rd bits, Dado3, the DW-bit sum Dado1+Dado2 (modulo 2^DW) and the carry-out into pipeline stage 1.
REQ-025 An accepted issue SHALL reach the queue tail exactly LAT cycles after acceptance; the pipeline SHALL accept one issue per cycle and SHALL NOT stall.
REQ-026 The result queue SHALL be a FIFO of DEPTH entries; entries SHALL leave in issue order.
REQ-027 Credits: occupancy SHALL count queued entries plus in-flight entries; busy SHALL equal (occupancy == DEPTH).
REQ-028 The queue SHALL never overflow; in-flight entries SHALL always have a reserved slot.
REQ-029 confirmacao SHALL be 1 exactly when the queue is non-empty.
REQ-030 While confirmacao=1, Resultado, StoreData and ovf SHALL present the head entry and hold it stable until it is popped.
REQ-031 A pop SHALL occur on an edge with finalizado=1 and confirmacao=1; finalizado with an empty queue SHALL be ignored.
REQ-032 Accept and pop in the same cycle SHALL both take effect, leaving occupancy unchanged; this SHALL hold at occupancy==DEPTH only if busy was 0 at accept time (so no accept occurs when full).
REQ-033 A pop at full SHALL deassert busy on the next cycle, not combinationally.
REQ-034 Pointer wrap-around SHALL be modulo DEPTH; non-power-of-two DEPTH SHALL be supported.
REQ-035 When the queue is empty, Resultado, StoreData and ovf SHALL be 0.
REQ-036 The opcode bits of OP_Rd SHALL NOT be stored.

Reset
REQ-037 When CLR=1 at a rising edge, the block SHALL drop all queued and in-flight entries and zero the pointers and occupancy.
REQ-038 After that edge, confirmacao=0, busy=0, desWrAS=1, ovf=0, and Resultado=0, StoreData=0 and occupancy=0.
REQ-039 CLR SHALL override a simultaneous start or finalizado.
REQ-040 Mid-operation reset SHALL lose all entries, and no stale entry SHALL appear after reset.

Verification
REQ-041 Single issue, LAT=1: Dado1=0x0010, Dado2=0x1000, ID_RS_in=5, Rd=3 -> next cycle confirmacao=1, Resultado={3'd3,4'd5,16'h1010}, desWrAS=0, ovf=0; finalizado -> empty the following cycle.
REQ-042 Carry: Dado1=0xFFFF, Dado2=0x0002 -> address 0x0001, ovf=1.
REQ-043 Fill, DEPTH=4, LAT=2, no finalizado: 4 back-to-back issues -> busy=1 once occupancy=4; 5th start ignored; results in order.
REQ-044 Simultaneous accept and pop at occupancy=2 -> occupancy stays 2; order preserved across pointer wrap, over 10 issues.
REQ-045 Reset with 3 entries in flight or queued -> next cycle all outputs at reset values; no entry emerges in the following LAT+2 cycles.
REQ-046 Spurious finalizado with empty queue -> no change; DEPTH=3 build passes the REQ-044 run.
